// File: rtl/ysyx_24090012_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4 arbiter, one transaction in flight.
// Optional macro ARB_RR_EN selects round-robin arbitration; default is fixed priority LSU over IFU.
module ysyx_24090012_axi_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                io_ifu_arvalid,
    input  logic [ADDR_W-1:0]   io_ifu_araddr,
    input  logic [ID_W-1:0]     io_ifu_arid,
    input  logic [7:0]          io_ifu_arlen,
    input  logic [2:0]          io_ifu_arsize,
    input  logic [1:0]          io_ifu_arburst,
    output logic                io_ifu_arready,
    output logic                io_ifu_rvalid,
    output logic [DATA_W-1:0]   io_ifu_rdata,
    output logic [1:0]          io_ifu_rresp,
    output logic [ID_W-1:0]     io_ifu_rid,
    output logic                io_ifu_rlast,
    input  logic                io_ifu_rready,

    input  logic                io_lsu_arvalid,
    input  logic [ADDR_W-1:0]   io_lsu_araddr,
    input  logic [ID_W-1:0]     io_lsu_arid,
    input  logic [7:0]          io_lsu_arlen,
    input  logic [2:0]          io_lsu_arsize,
    input  logic [1:0]          io_lsu_arburst,
    output logic                io_lsu_arready,
    output logic                io_lsu_rvalid,
    output logic [DATA_W-1:0]   io_lsu_rdata,
    output logic [1:0]          io_lsu_rresp,
    output logic [ID_W-1:0]     io_lsu_rid,
    output logic                io_lsu_rlast,
    input  logic                io_lsu_rready,
    input  logic                io_lsu_awvalid,
    input  logic [ADDR_W-1:0]   io_lsu_awaddr,
    input  logic [ID_W-1:0]     io_lsu_awid,
    input  logic [7:0]          io_lsu_awlen,
    input  logic [2:0]          io_lsu_awsize,
    input  logic [1:0]          io_lsu_awburst,
    output logic                io_lsu_awready,
    input  logic                io_lsu_wvalid,
    input  logic [DATA_W-1:0]   io_lsu_wdata,
    input  logic [DATA_W/8-1:0] io_lsu_wstrb,
    input  logic                io_lsu_wlast,
    output logic                io_lsu_wready,
    output logic                io_lsu_bvalid,
    output logic [1:0]          io_lsu_bresp,
    output logic [ID_W-1:0]     io_lsu_bid,
    input  logic                io_lsu_bready,

    output logic                io_master_awvalid,
    output logic [ADDR_W-1:0]   io_master_awaddr,
    output logic [ID_W-1:0]     io_master_awid,
    output logic [7:0]          io_master_awlen,
    output logic [2:0]          io_master_awsize,
    output logic [1:0]          io_master_awburst,
    input  logic                io_master_awready,
    output logic                io_master_wvalid,
    output logic [DATA_W-1:0]   io_master_wdata,
    output logic [DATA_W/8-1:0] io_master_wstrb,
    output logic                io_master_wlast,
    input  logic                io_master_wready,
    input  logic                io_master_bvalid,
    input  logic [1:0]          io_master_bresp,
    input  logic [ID_W-1:0]     io_master_bid,
    output logic                io_master_bready,
    output logic                io_master_arvalid,
    output logic [ADDR_W-1:0]   io_master_araddr,
    output logic [ID_W-1:0]     io_master_arid,
    output logic [7:0]          io_master_arlen,
    output logic [2:0]          io_master_arsize,
    output logic [1:0]          io_master_arburst,
    input  logic                io_master_arready,
    input  logic                io_master_rvalid,
    input  logic [DATA_W-1:0]   io_master_rdata,
    input  logic [1:0]          io_master_rresp,
    input  logic [ID_W-1:0]     io_master_rid,
    input  logic                io_master_rlast,
    output logic                io_master_rready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic ifu_req;
    logic lsu_req;
    logic grant_lsu;
    logic r_done;
    logic b_done;

    assign ifu_req = io_ifu_arvalid;
    assign lsu_req = io_lsu_awvalid | io_lsu_arvalid;

    // Completion is judged on the downstream handshake the arbiter itself is forwarding.
    assign r_done = io_master_rvalid & io_master_rready & io_master_rlast;
    assign b_done = io_master_bvalid & io_master_bready;

`ifdef ARB_RR_EN
    // last_grant_q: 1'b0 = IFU served last, 1'b1 = LSU served last.
    logic last_grant_q, last_grant_d;

    assign grant_lsu = lsu_req & (~ifu_req | ~last_grant_q);

    always_ff @(posedge clock) begin : last_grant_reg
        if (reset) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin : last_grant_next
        last_grant_d = last_grant_q;
        if (state_q == IDLE && (ifu_req || lsu_req)) begin
            last_grant_d = grant_lsu;
        end
    end
`else
    assign grant_lsu = lsu_req;
`endif

    always_ff @(posedge clock) begin : state_reg
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : state_next
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_lsu) begin
                    state_d = io_lsu_awvalid ? LSU_WR : LSU_RD;
                end else if (ifu_req) begin
                    state_d = IFU_RD;
                end
            end
            IFU_RD, LSU_RD: begin
                if (r_done) begin
                    state_d = IDLE;
                end
            end
            LSU_WR: begin
                if (b_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response payloads are broadcast to both masters; only the valid is steered.
    assign io_ifu_rdata = io_master_rdata;
    assign io_ifu_rresp = io_master_rresp;
    assign io_ifu_rid   = io_master_rid;
    assign io_ifu_rlast = io_master_rlast;
    assign io_lsu_rdata = io_master_rdata;
    assign io_lsu_rresp = io_master_rresp;
    assign io_lsu_rid   = io_master_rid;
    assign io_lsu_rlast = io_master_rlast;
    assign io_lsu_bresp = io_master_bresp;
    assign io_lsu_bid   = io_master_bid;

    always_comb begin : channel_mux
        io_master_arvalid = 1'b0;
        io_master_araddr  = '0;
        io_master_arid    = '0;
        io_master_arlen   = '0;
        io_master_arsize  = '0;
        io_master_arburst = '0;
        io_master_rready  = 1'b0;
        io_master_awvalid = 1'b0;
        io_master_awaddr  = '0;
        io_master_awid    = '0;
        io_master_awlen   = '0;
        io_master_awsize  = '0;
        io_master_awburst = '0;
        io_master_wvalid  = 1'b0;
        io_master_wdata   = '0;
        io_master_wstrb   = '0;
        io_master_wlast   = 1'b0;
        io_master_bready  = 1'b0;
        io_ifu_arready    = 1'b0;
        io_ifu_rvalid     = 1'b0;
        io_lsu_arready    = 1'b0;
        io_lsu_rvalid     = 1'b0;
        io_lsu_awready    = 1'b0;
        io_lsu_wready     = 1'b0;
        io_lsu_bvalid     = 1'b0;
        case (state_q)
            IFU_RD: begin
                io_master_arvalid = io_ifu_arvalid;
                io_master_araddr  = io_ifu_araddr;
                io_master_arid    = io_ifu_arid;
                io_master_arlen   = io_ifu_arlen;
                io_master_arsize  = io_ifu_arsize;
                io_master_arburst = io_ifu_arburst;
                io_master_rready  = io_ifu_rready;
                io_ifu_arready    = io_master_arready;
                io_ifu_rvalid     = io_master_rvalid;
            end
            LSU_RD: begin
                io_master_arvalid = io_lsu_arvalid;
                io_master_araddr  = io_lsu_araddr;
                io_master_arid    = io_lsu_arid;
                io_master_arlen   = io_lsu_arlen;
                io_master_arsize  = io_lsu_arsize;
                io_master_arburst = io_lsu_arburst;
                io_master_rready  = io_lsu_rready;
                io_lsu_arready    = io_master_arready;
                io_lsu_rvalid     = io_master_rvalid;
            end
            LSU_WR: begin
                io_master_awvalid = io_lsu_awvalid;
                io_master_awaddr  = io_lsu_awaddr;
                io_master_awid    = io_lsu_awid;
                io_master_awlen   = io_lsu_awlen;
                io_master_awsize  = io_lsu_awsize;
                io_master_awburst = io_lsu_awburst;
                io_master_wvalid  = io_lsu_wvalid;
                io_master_wdata   = io_lsu_wdata;
                io_master_wstrb   = io_lsu_wstrb;
                io_master_wlast   = io_lsu_wlast;
                io_master_bready  = io_lsu_bready;
                io_lsu_awready    = io_master_awready;
                io_lsu_wready     = io_master_wready;
                io_lsu_bvalid     = io_master_bvalid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_24090012_axi_arbiter.sv
// Directed testbench for ysyx_24090012_axi_arbiter; expectations follow ARB_RR_EN when defined.
module tb_ysyx_24090012_axi_arbiter;

    logic        clock;
    logic        reset;
    logic        io_ifu_arvalid, io_ifu_arready, io_ifu_rvalid, io_ifu_rlast, io_ifu_rready;
    logic [31:0] io_ifu_araddr, io_ifu_rdata;
    logic [3:0]  io_ifu_arid, io_ifu_rid;
    logic [7:0]  io_ifu_arlen;
    logic [2:0]  io_ifu_arsize;
    logic [1:0]  io_ifu_arburst, io_ifu_rresp;
    logic        io_lsu_arvalid, io_lsu_arready, io_lsu_rvalid, io_lsu_rlast, io_lsu_rready;
    logic [31:0] io_lsu_araddr, io_lsu_rdata;
    logic [3:0]  io_lsu_arid, io_lsu_rid;
    logic [7:0]  io_lsu_arlen;
    logic [2:0]  io_lsu_arsize;
    logic [1:0]  io_lsu_arburst, io_lsu_rresp;
    logic        io_lsu_awvalid, io_lsu_awready, io_lsu_wvalid, io_lsu_wlast, io_lsu_wready;
    logic [31:0] io_lsu_awaddr, io_lsu_wdata;
    logic [3:0]  io_lsu_awid, io_lsu_wstrb, io_lsu_bid;
    logic [7:0]  io_lsu_awlen;
    logic [2:0]  io_lsu_awsize;
    logic [1:0]  io_lsu_awburst, io_lsu_bresp;
    logic        io_lsu_bvalid, io_lsu_bready;
    logic        io_master_awvalid, io_master_awready, io_master_wvalid, io_master_wlast, io_master_wready;
    logic [31:0] io_master_awaddr, io_master_wdata;
    logic [3:0]  io_master_awid, io_master_wstrb, io_master_bid;
    logic [7:0]  io_master_awlen;
    logic [2:0]  io_master_awsize;
    logic [1:0]  io_master_awburst, io_master_bresp;
    logic        io_master_bvalid, io_master_bready;
    logic        io_master_arvalid, io_master_arready, io_master_rvalid, io_master_rlast, io_master_rready;
    logic [31:0] io_master_araddr, io_master_rdata;
    logic [3:0]  io_master_arid, io_master_rid;
    logic [7:0]  io_master_arlen;
    logic [2:0]  io_master_arsize;
    logic [1:0]  io_master_arburst, io_master_rresp;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] vr;
    assign vr = {io_ifu_arready, io_ifu_rvalid, io_lsu_arready, io_lsu_rvalid, io_lsu_awready,
                 io_lsu_wready, io_lsu_bvalid, io_master_awvalid, io_master_wvalid,
                 io_master_bready, io_master_arvalid, io_master_rready};

    ysyx_24090012_axi_arbiter dut (
        .clock(clock), .reset(reset),
        .io_ifu_arvalid(io_ifu_arvalid), .io_ifu_araddr(io_ifu_araddr), .io_ifu_arid(io_ifu_arid),
        .io_ifu_arlen(io_ifu_arlen), .io_ifu_arsize(io_ifu_arsize), .io_ifu_arburst(io_ifu_arburst),
        .io_ifu_arready(io_ifu_arready), .io_ifu_rvalid(io_ifu_rvalid), .io_ifu_rdata(io_ifu_rdata),
        .io_ifu_rresp(io_ifu_rresp), .io_ifu_rid(io_ifu_rid), .io_ifu_rlast(io_ifu_rlast),
        .io_ifu_rready(io_ifu_rready),
        .io_lsu_arvalid(io_lsu_arvalid), .io_lsu_araddr(io_lsu_araddr), .io_lsu_arid(io_lsu_arid),
        .io_lsu_arlen(io_lsu_arlen), .io_lsu_arsize(io_lsu_arsize), .io_lsu_arburst(io_lsu_arburst),
        .io_lsu_arready(io_lsu_arready), .io_lsu_rvalid(io_lsu_rvalid), .io_lsu_rdata(io_lsu_rdata),
        .io_lsu_rresp(io_lsu_rresp), .io_lsu_rid(io_lsu_rid), .io_lsu_rlast(io_lsu_rlast),
        .io_lsu_rready(io_lsu_rready),
        .io_lsu_awvalid(io_lsu_awvalid), .io_lsu_awaddr(io_lsu_awaddr), .io_lsu_awid(io_lsu_awid),
        .io_lsu_awlen(io_lsu_awlen), .io_lsu_awsize(io_lsu_awsize), .io_lsu_awburst(io_lsu_awburst),
        .io_lsu_awready(io_lsu_awready), .io_lsu_wvalid(io_lsu_wvalid), .io_lsu_wdata(io_lsu_wdata),
        .io_lsu_wstrb(io_lsu_wstrb), .io_lsu_wlast(io_lsu_wlast), .io_lsu_wready(io_lsu_wready),
        .io_lsu_bvalid(io_lsu_bvalid), .io_lsu_bresp(io_lsu_bresp), .io_lsu_bid(io_lsu_bid),
        .io_lsu_bready(io_lsu_bready),
        .io_master_awvalid(io_master_awvalid), .io_master_awaddr(io_master_awaddr),
        .io_master_awid(io_master_awid), .io_master_awlen(io_master_awlen),
        .io_master_awsize(io_master_awsize), .io_master_awburst(io_master_awburst),
        .io_master_awready(io_master_awready), .io_master_wvalid(io_master_wvalid),
        .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
        .io_master_wlast(io_master_wlast), .io_master_wready(io_master_wready),
        .io_master_bvalid(io_master_bvalid), .io_master_bresp(io_master_bresp),
        .io_master_bid(io_master_bid), .io_master_bready(io_master_bready),
        .io_master_arvalid(io_master_arvalid), .io_master_araddr(io_master_araddr),
        .io_master_arid(io_master_arid), .io_master_arlen(io_master_arlen),
        .io_master_arsize(io_master_arsize), .io_master_arburst(io_master_arburst),
        .io_master_arready(io_master_arready), .io_master_rvalid(io_master_rvalid),
        .io_master_rdata(io_master_rdata), .io_master_rresp(io_master_rresp),
        .io_master_rid(io_master_rid), .io_master_rlast(io_master_rlast),
        .io_master_rready(io_master_rready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the active edge; checks follow a further #1.
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // Completes a single-beat read for the currently granted master (1 = LSU, 0 = IFU).
    task automatic serve_read(input string tag, input logic lsu_side, input logic [31:0] data);
        io_master_arready = 1'b1;
        #1;
        check({tag, "_arready"}, 32'(lsu_side ? io_lsu_arready : io_ifu_arready), 32'(1));
        check({tag, "_other_arready"}, 32'(lsu_side ? io_ifu_arready : io_lsu_arready), 32'(0));
        step();
        io_master_arready = 1'b0;
        if (lsu_side) io_lsu_arvalid = 1'b0;
        else          io_ifu_arvalid = 1'b0;
        io_master_rvalid = 1'b1;
        io_master_rdata  = data;
        io_master_rlast  = 1'b1;
        #1;
        check({tag, "_rvalid"}, 32'(lsu_side ? io_lsu_rvalid : io_ifu_rvalid), 32'(1));
        check({tag, "_other_rvalid"}, 32'(lsu_side ? io_ifu_rvalid : io_lsu_rvalid), 32'(0));
        check({tag, "_rdata"}, lsu_side ? io_lsu_rdata : io_ifu_rdata, data);
        step();
        io_master_rvalid = 1'b0;
        io_master_rlast  = 1'b0;
    endtask

    logic w1_lsu, w2_lsu;

    initial begin
        reset = 1'b1;
        {io_ifu_arvalid, io_ifu_araddr, io_ifu_arid, io_ifu_arlen, io_ifu_arsize, io_ifu_arburst} = '0;
        {io_lsu_arvalid, io_lsu_araddr, io_lsu_arid, io_lsu_arlen, io_lsu_arsize, io_lsu_arburst} = '0;
        {io_lsu_awvalid, io_lsu_awaddr, io_lsu_awid, io_lsu_awlen, io_lsu_awsize, io_lsu_awburst} = '0;
        {io_lsu_wvalid, io_lsu_wdata, io_lsu_wstrb, io_lsu_wlast} = '0;
        io_ifu_rready = 1'b1;
        io_lsu_rready = 1'b1;
        io_lsu_bready = 1'b1;
        {io_master_awready, io_master_wready, io_master_arready} = '0;
        {io_master_bvalid, io_master_bresp, io_master_bid} = '0;
        {io_master_rvalid, io_master_rdata, io_master_rresp, io_master_rid, io_master_rlast} = '0;
        step();
        step();
        #1;
        check("reset_outputs", 32'(vr), 32'(0));
        reset = 1'b0;
        step();
        #1;
        check("idle_outputs", 32'(vr), 32'(0));

        // IFU-only read with a 3-cycle arready delay.
        io_ifu_arvalid = 1'b1; io_ifu_araddr = 32'h8000_0000; io_ifu_arid = 4'd1;
        io_ifu_arsize = 3'd2; io_ifu_arburst = 2'd1;
        #1;
        check("t1_idle_no_fwd", 32'(io_master_arvalid), 32'(0));
        check("t1_idle_araddr_zero", io_master_araddr, 32'h0);
        step(); #1;
        check("t1_arvalid", 32'(io_master_arvalid), 32'(1));
        check("t1_araddr", io_master_araddr, 32'h8000_0000);
        check("t1_arid", 32'(io_master_arid), 32'(1));
        check("t1_ifu_arready_wait", 32'(io_ifu_arready), 32'(0));
        check("t1_no_aw", 32'(io_master_awvalid), 32'(0));
        step(); step(); #1;
        check("t1_arvalid_held", 32'(io_master_arvalid), 32'(1));
        check("t1_lsu_readies", 32'({io_lsu_arready, io_lsu_awready, io_lsu_wready}), 32'(0));
        serve_read("t1", 1'b0, 32'hDEAD_BEEF);
        #1;
        check("t1_back_idle", 32'(vr), 32'(0));

        // LSU single-beat write.
        io_lsu_awvalid = 1'b1; io_lsu_awaddr = 32'h8000_0100; io_lsu_awid = 4'd3;
        io_lsu_awsize = 3'd2; io_lsu_awburst = 2'd1;
        io_lsu_wvalid = 1'b1; io_lsu_wdata = 32'h1234_5678; io_lsu_wstrb = 4'hF; io_lsu_wlast = 1'b1;
        #1;
        check("t2_idle_no_aw", 32'(io_master_awvalid), 32'(0));
        step(); #1;
        check("t2_awvalid", 32'(io_master_awvalid), 32'(1));
        check("t2_awaddr", io_master_awaddr, 32'h8000_0100);
        check("t2_awid", 32'(io_master_awid), 32'(3));
        check("t2_wvalid", 32'(io_master_wvalid), 32'(1));
        check("t2_wdata", io_master_wdata, 32'h1234_5678);
        check("t2_wstrb_wlast", 32'({io_master_wstrb, io_master_wlast}), 32'h1F);
        check("t2_no_ar", 32'(io_master_arvalid), 32'(0));
        io_master_awready = 1'b1; io_master_wready = 1'b1;
        #1;
        check("t2_aw_w_ready", 32'({io_lsu_awready, io_lsu_wready}), 32'h3);
        step();
        io_lsu_awvalid = 1'b0; io_lsu_wvalid = 1'b0;
        io_master_awready = 1'b0; io_master_wready = 1'b0;
        io_master_bvalid = 1'b1; io_master_bresp = 2'b00; io_master_bid = 4'd3;
        #1;
        check("t2_bvalid", 32'(io_lsu_bvalid), 32'(1));
        check("t2_bid_bresp", 32'({io_lsu_bid, io_lsu_bresp}), 32'h0C);
        check("t2_no_ar_b", 32'({io_master_arvalid, io_ifu_rvalid}), 32'(0));
        step();
        io_master_bvalid = 1'b0;
        #1;
        check("t2_back_idle", 32'(vr), 32'(0));

        // Simultaneous IFU/LSU reads, twice; last grant before this point was LSU.
`ifdef ARB_RR_EN
        w1_lsu = 1'b0; w2_lsu = 1'b1;
`else
        w1_lsu = 1'b1; w2_lsu = 1'b1;
`endif
        io_ifu_arvalid = 1'b1; io_ifu_araddr = 32'h0000_1000;
        io_lsu_arvalid = 1'b1; io_lsu_araddr = 32'h0000_2000;
        step(); #1;
        check("t3_first_addr", io_master_araddr, w1_lsu ? 32'h0000_2000 : 32'h0000_1000);
        serve_read("t3a", w1_lsu, 32'h0000_00A1);
        if (w1_lsu) io_lsu_arvalid = 1'b1;
        else        io_ifu_arvalid = 1'b1;
        #1;
        check("t3_idle_between", 32'(io_master_arvalid), 32'(0));
        step(); #1;
        check("t3_second_addr", io_master_araddr, w2_lsu ? 32'h0000_2000 : 32'h0000_1000);
        serve_read("t3b", w2_lsu, 32'h0000_00A2);
        step(); #1;
        check("t3_third_ifu", io_master_araddr, 32'h0000_1000);
        serve_read("t3c", 1'b0, 32'h0000_00A3);

        // LSU write and read together: write first, read after B.
        io_lsu_awvalid = 1'b1; io_lsu_awaddr = 32'h0000_0300; io_lsu_wvalid = 1'b1;
        io_lsu_arvalid = 1'b1; io_lsu_araddr = 32'h0000_3000;
        step(); #1;
        check("t4_write_first", 32'({io_master_awvalid, io_master_arvalid}), 32'h2);
        io_master_awready = 1'b1; io_master_wready = 1'b1;
        step();
        io_lsu_awvalid = 1'b0; io_lsu_wvalid = 1'b0;
        io_master_awready = 1'b0; io_master_wready = 1'b0;
        step(); #1;
        check("t4_no_ar_before_b", 32'(io_master_arvalid), 32'(0));
        io_master_bvalid = 1'b1;
        #1;
        check("t4_bvalid", 32'(io_lsu_bvalid), 32'(1));
        step();
        io_master_bvalid = 1'b0;
        #1;
        check("t4_idle_after_b", 32'(io_master_arvalid), 32'(0));
        step(); #1;
        check("t4_read_after", 32'(io_master_arvalid), 32'(1));
        check("t4_read_addr", io_master_araddr, 32'h0000_3000);
        serve_read("t4", 1'b1, 32'h0000_00B4);

        // IFU burst of 4; LSU requests during beat 2.
        io_ifu_arvalid = 1'b1; io_ifu_araddr = 32'h0000_4000; io_ifu_arlen = 8'd3;
        step(); #1;
        check("t5_arlen", 32'(io_master_arlen), 32'(3));
        io_master_arready = 1'b1;
        step();
        io_master_arready = 1'b0; io_ifu_arvalid = 1'b0;
        io_master_rvalid = 1'b1; io_master_rdata = 32'h0000_0001;
        step();
        io_master_rdata = 32'h0000_0002;
        io_lsu_arvalid = 1'b1; io_lsu_araddr = 32'h0000_5000;
        #1;
        check("t5_beat2_lsu_blocked", 32'({io_lsu_arready, io_master_arvalid}), 32'(0));
        step();
        io_master_rdata = 32'h0000_0003;
        #1;
        check("t5_beat3_lsu_blocked", 32'({io_lsu_arready, io_master_arvalid}), 32'(0));
        step();
        io_master_rdata = 32'h0000_0004; io_master_rlast = 1'b1;
        #1;
        check("t5_beat4_rlast", 32'({io_ifu_rvalid, io_ifu_rlast, io_lsu_rvalid}), 32'h6);
        check("t5_beat4_data", io_ifu_rdata, 32'h0000_0004);
        step();
        io_master_rvalid = 1'b0; io_master_rlast = 1'b0;
        #1;
        check("t5_m1_idle", 32'(io_master_arvalid), 32'(0));
        step(); #1;
        check("t5_m2_lsu_grant", 32'(io_master_arvalid), 32'(1));
        check("t5_m2_lsu_addr", io_master_araddr, 32'h0000_5000);

        // Reset while in LSU_RD with read data pending.
        io_master_rvalid = 1'b1;
        #1;
        check("t6_pending_rvalid", 32'(io_lsu_rvalid), 32'(1));
        reset = 1'b1;
        step(); #1;
        check("t6_reset_idle", 32'(vr), 32'(0));
        reset = 1'b0;
        io_lsu_arvalid = 1'b0; io_master_rvalid = 1'b0;
        step(); #1;
        check("t6_after_reset", 32'(vr), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
